// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Optional feature macro: BCD_SIGNED_EN (two's complement input handling in bin2bcd_seq).
`timescale 1ns/1ps

package bcd_pkg;

  // Converter control states: waiting, shifting one bit per clock, result cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Saturation digit used when the result does not fit on the display.
  localparam logic [3:0] BCD_NINE = 4'h9;

  // Number of decimal digits needed to hold any bin_w-bit value
  // (log10(2) ~= 0.302, rounded up).
  function automatic int int_digits(input int bin_w);
    return (bin_w * 302 + 999) / 1000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction step of the shift-and-add-3 algorithm:
// a digit of 5 or more gets +3 so the following left shift carries correctly.
`timescale 1ns/1ps

module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Add 3 to digits 5..9 before they are doubled by the next shift.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// The registered result feeds the seven-segment scanner directly, so bcd_out,
// ovf and neg only ever change on the cycle a conversion completes (or on reset).
// Optional feature macro: BCD_SIGNED_EN -- treat bin_in as two's complement and
// convert its magnitude, flagging negative inputs on neg.
`timescale 1ns/1ps

module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  neg
);

  localparam int INT_DIG = int_digits(BIN_W);
  localparam int ACC_W   = 4 * INT_DIG;
  localparam int CNT_W   = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e                state_q, state_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  negPend_q, negPend_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic                  neg_q, neg_d;

  logic [ACC_W-1:0]      accAdj;
  logic [ACC_W-1:0]      accShift;
  logic [BIN_W-1:0]      binShift;
  logic [BIN_W-1:0]      loadVal;
  logic                  loadNeg;
  logic                  ovfC;

  // One add-3 corrector per internal digit, all working on the current accumulator.
  for (genvar g = 0; g < INT_DIG; g++) begin : gAdj
    bcd_digit_adj uAdj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (accAdj[4*g +: 4])
    );
  end

  // The corrected accumulator and the remaining binary bits move left as one word.
  assign {accShift, binShift} = {accAdj, bin_q} << 1;

`ifdef BCD_SIGNED_EN
  // Negative inputs are converted as their magnitude; the most negative value
  // maps onto itself, which read unsigned is exactly 2**(BIN_W-1).
  assign loadNeg = bin_in[BIN_W-1];
  assign loadVal = loadNeg ? ((~bin_in) + BIN_W'(1)) : bin_in;
`else
  // Unsigned input goes straight into the shift register.
  assign loadNeg = 1'b0;
  assign loadVal = bin_in;
`endif

  // Digits above the displayed ones being nonzero means the value cannot be shown.
  always_comb begin
    ovfC = 1'b0;
    for (int i = DIGITS; i < INT_DIG; i++) begin
      ovfC = ovfC | (|accShift[4*i +: 4]);
    end
  end

  // Next-state logic: accept in IDLE/DONE, shift BIN_W times, publish on the last shift.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    negPend_d = negPend_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SHIFT;
          bin_d     = loadVal;
          acc_d     = '0;
          cnt_d     = '0;
          negPend_d = loadNeg;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bin_d = binShift;
        acc_d = accShift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          ovf_d   = ovfC;
          neg_d   = negPend_q;
          bcd_d   = ovfC ? {DIGITS{BCD_NINE}} : accShift[4*DIGITS-1:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      negPend_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      negPend_q <= negPend_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
  assign neg     = neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (BIN_W=16, DIGITS=4).
// Expected results come from a decimal arithmetic model; BCD_SIGNED_EN is honoured
// by the model so the same bench covers both builds.
`timescale 1ns/1ps

module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;
  logic        neg;

  int checkCount = 0;
  int errorCount = 0;

  logic [15:0] heldBcd;
  logic        heldOvf;
  logic        heldNeg;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf),
    .neg     (neg)
  );

  // Decimal reference: magnitude, saturation at 10**DIGITS, digits by repeated /10.
  function automatic void refModel(input logic [15:0] v, output logic [15:0] bcd,
                                   output logic o, output logic n);
    longint mag;
    longint rest;
    n   = 1'b0;
    mag = longint'(v);
`ifdef BCD_SIGNED_EN
    if (v[15]) begin
      n   = 1'b1;
      mag = 65536 - longint'(v);
    end
`endif
    o   = (mag >= 10000);
    bcd = '0;
    if (o) begin
      bcd = 16'h9999;
    end else begin
      rest = mag;
      for (int i = 0; i < 4; i++) begin
        bcd[4*i +: 4] = 4'(rest % 10);
        rest = rest / 10;
      end
    end
  endfunction

  // Single conversion: latency, busy length, output stability, result, done pulse width.
  task automatic test_conversion(input logic [15:0] value, input string tag);
    logic [15:0] expBcd;
    logic        expOvf;
    logic        expNeg;
    int          cycles;
    int          busyCycles;
    bit          stable;
    refModel(value, expBcd, expOvf, expNeg);
    bin_in = value;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'($urandom);
    cycles = 1;
    busyCycles = 0;
    stable = 1'b1;
    while (!done && cycles < 40) begin
      if (busy) busyCycles++;
      if (bcd_out !== heldBcd || ovf !== heldOvf || neg !== heldNeg) stable = 1'b0;
      @(negedge clk);
      cycles++;
    end
    checkCount++;
    if (cycles !== 17) begin
      errorCount++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected 17", tag, cycles);
    end
    checkCount++;
    if (busyCycles !== 16) begin
      errorCount++;
      $display("[TB] FAIL %s busy_len: got %0d, expected 16", tag, busyCycles);
    end
    checkCount++;
    if (!stable) begin
      errorCount++;
      $display("[TB] FAIL %s outputs_stable: outputs changed before done, expected held %h", tag, heldBcd);
    end
    checkCount++;
    if (busy !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL %s busy_at_done: got %b, expected 0", tag, busy);
    end
    checkCount++;
    if (bcd_out !== expBcd) begin
      errorCount++;
      $display("[TB] FAIL %s bcd_out (in=%h): got %h, expected %h", tag, value, bcd_out, expBcd);
    end
    checkCount++;
    if (ovf !== expOvf) begin
      errorCount++;
      $display("[TB] FAIL %s ovf (in=%h): got %b, expected %b", tag, value, ovf, expOvf);
    end
    checkCount++;
    if (neg !== expNeg) begin
      errorCount++;
      $display("[TB] FAIL %s neg (in=%h): got %b, expected %b", tag, value, neg, expNeg);
    end
    heldBcd = expBcd;
    heldOvf = expOvf;
    heldNeg = expNeg;
    @(negedge clk);
    checkCount++;
    if (done !== 1'b0 || bcd_out !== heldBcd) begin
      errorCount++;
      $display("[TB] FAIL %s after_done: got done=%b bcd=%h, expected done=0 bcd=%h",
               tag, done, bcd_out, heldBcd);
    end
  endtask

  // Reset values, then an asynchronous reset in the middle of a conversion.
  task automatic test_reset();
    int doneSeen;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    #12;
    checkCount++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000 || ovf !== 1'b0 || neg !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_values: got busy=%b done=%b bcd=%h ovf=%b neg=%b, expected all 0",
               busy, done, bcd_out, ovf, neg);
    end
    @(negedge clk);
    reset   = 1'b0;
    heldBcd = 16'h0000;
    heldOvf = 1'b0;
    heldNeg = 1'b0;
    @(negedge clk);
    test_conversion(16'd1234, "pre_reset");
    bin_in = 16'd4321;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkCount++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000 || ovf !== 1'b0 || neg !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL midshift_reset: got busy=%b done=%b bcd=%h ovf=%b neg=%b, expected all 0",
               busy, done, bcd_out, ovf, neg);
    end
    @(negedge clk);
    reset   = 1'b0;
    heldBcd = 16'h0000;
    heldOvf = 1'b0;
    heldNeg = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checkCount++;
    if (doneSeen !== 0) begin
      errorCount++;
      $display("[TB] FAIL no_done_after_reset: got %0d active cycles, expected 0", doneSeen);
    end
  endtask

  // Boundary values including overflow and the signed corner cases.
  task automatic test_boundaries();
    test_conversion(16'd1234,  "val_1234");
    test_conversion(16'd0,     "val_0");
    test_conversion(16'd9999,  "val_9999");
    test_conversion(16'd10000, "val_10000");
    test_conversion(16'hFFFF,  "val_FFFF");
    test_conversion(16'hFB2E,  "val_FB2E");
    test_conversion(16'h8000,  "val_8000");
    test_conversion(16'd10,    "val_10");
  endtask

  // Random values, half constrained to the displayable range.
  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) v = 16'($urandom_range(0, 9999));
      else            v = 16'($urandom);
      test_conversion(v, "random");
    end
  endtask

  // A start pulse during SHIFT must not disturb the conversion in flight.
  task automatic test_ignore_start();
    logic [15:0] valA;
    logic [15:0] expBcd;
    logic        expOvf;
    logic        expNeg;
    int          cycles;
    valA = 16'($urandom_range(0, 9999));
    refModel(valA, expBcd, expOvf, expNeg);
    bin_in = valA;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    repeat (2) begin
      @(negedge clk);
      cycles++;
    end
    bin_in = valA ^ 16'h5A5A;
    start  = 1'b1;
    @(negedge clk);
    cycles++;
    start  = 1'b0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkCount++;
    if (cycles !== 17) begin
      errorCount++;
      $display("[TB] FAIL ignore_start latency: got %0d, expected 17", cycles);
    end
    checkCount++;
    if (bcd_out !== expBcd || ovf !== expOvf || neg !== expNeg) begin
      errorCount++;
      $display("[TB] FAIL ignore_start result: got %h/%b/%b, expected %h/%b/%b",
               bcd_out, ovf, neg, expBcd, expOvf, expNeg);
    end
    heldBcd = expBcd;
    heldOvf = expOvf;
    heldNeg = expNeg;
    @(negedge clk);
  endtask

  // Start held through DONE: second conversion begins immediately, done pulses 17 apart.
  task automatic test_back_to_back();
    logic [15:0] valC;
    logic [15:0] valD;
    logic [15:0] expC;
    logic [15:0] expD;
    logic        oC, nC, oD, nD;
    int          cycles;
    valC = 16'($urandom_range(0, 9999));
    valD = 16'($urandom);
    refModel(valC, expC, oC, nC);
    refModel(valD, expD, oD, nD);
    bin_in = valC;
    start  = 1'b1;
    @(negedge clk);
    bin_in = valD;
    cycles = 1;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkCount++;
    if (cycles !== 17 || bcd_out !== expC || ovf !== oC || neg !== nC) begin
      errorCount++;
      $display("[TB] FAIL b2b_first: got %0d cycles %h/%b/%b, expected 17 cycles %h/%b/%b",
               cycles, bcd_out, ovf, neg, expC, oC, nC);
    end
    @(negedge clk);
    start = 1'b0;
    checkCount++;
    if (done !== 1'b0 || busy !== 1'b1 || bcd_out !== expC) begin
      errorCount++;
      $display("[TB] FAIL b2b_restart: got done=%b busy=%b bcd=%h, expected done=0 busy=1 bcd=%h",
               done, busy, bcd_out, expC);
    end
    cycles = 1;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkCount++;
    if (cycles !== 17) begin
      errorCount++;
      $display("[TB] FAIL b2b_spacing: got %0d cycles between done pulses, expected 17", cycles);
    end
    checkCount++;
    if (bcd_out !== expD || ovf !== oD || neg !== nD) begin
      errorCount++;
      $display("[TB] FAIL b2b_second (in=%h): got %h/%b/%b, expected %h/%b/%b",
               valD, bcd_out, ovf, neg, expD, oD, nD);
    end
    heldBcd = expD;
    heldOvf = oD;
    heldNeg = nD;
    @(negedge clk);
  endtask

  // Hard stop in case the design wedges somewhere unexpected.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    test_reset();
    test_boundaries();
    test_random();
    test_ignore_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
